ofs_fim_pcie_ss_tx_arb: RTL and testbench

Packet-atomic weighted round-robin arbiter in the hip_clk domain that merges the header-only read-request stream (txreq) and the multi-beat write/completion stream (tx) onto the single PCIe SS TX AXI-S port. Each source enters already side-band encoded and clock-crossed. Output is registered. Per-source packet counters are exported for CSR visibility.

---
 rtl/ofs_fim_pcie_ss_tx_arb_if.sv | 44 ++++
 rtl/ofs_fim_pcie_ss_tx_arb.sv | 162 ++++++++++++++++
 tb/tb_ofs_fim_pcie_ss_tx_arb.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ofs_fim_pcie_ss_tx_arb_if.sv
// Handshake and beat bundle for the PCIe SS TX arbiter: the txreq and tx
// inputs plus the merged output, grouped so the arbiter takes one port.
interface ofs_fim_pcie_ss_tx_arb_if #(
    parameter int TDATA_WIDTH = 512,
    parameter int TKEEP_WIDTH = TDATA_WIDTH / 8,
    parameter int USER_W      = 259
);
    logic                   txreq_tvalid;
    logic                   txreq_tready;
    logic [USER_W-1:0]      txreq_tuser;

    logic                   tx_tvalid;
    logic                   tx_tready;
    logic [TDATA_WIDTH-1:0] tx_tdata;
    logic [TKEEP_WIDTH-1:0] tx_tkeep;
    logic                   tx_tlast;
    logic [USER_W-1:0]      tx_tuser;

    logic                   out_tvalid;
    logic                   out_tready;
    logic [TDATA_WIDTH-1:0] out_tdata;
    logic [TKEEP_WIDTH-1:0] out_tkeep;
    logic                   out_tlast;
    logic [USER_W-1:0]      out_tuser;
    logic                   out_src;

    modport slave (
        input  txreq_tvalid, txreq_tuser,
        input  tx_tvalid, tx_tdata, tx_tkeep, tx_tlast, tx_tuser,
        input  out_tready,
        output txreq_tready, tx_tready,
        output out_tvalid, out_tdata, out_tkeep, out_tlast,
        output out_tuser, out_src
    );

    modport master (
        output txreq_tvalid, txreq_tuser,
        output tx_tvalid, tx_tdata, tx_tkeep, tx_tlast, tx_tuser,
        output out_tready,
        input  txreq_tready, tx_tready,
        input  out_tvalid, out_tdata, out_tkeep, out_tlast,
        input  out_tuser, out_src
    );
endinterface

// File: rtl/ofs_fim_pcie_ss_tx_arb.sv
// Packet-atomic weighted round-robin merge of txreq (header-only) and tx
// (multi-beat) onto one registered PCIe SS TX stream, with packet counters.
module ofs_fim_pcie_ss_tx_arb #(
    parameter int TDATA_WIDTH = 512,
    parameter int TKEEP_WIDTH = TDATA_WIDTH / 8,
    parameter int USER_W      = 259
) (
    input  logic                     hip_clk,
    input  logic                     hip_rst_n,
    input  logic [3:0]               cfg_txreq_weight,
    input  logic [3:0]               cfg_tx_weight,
    ofs_fim_pcie_ss_tx_arb_if.slave  bus,
    output logic [31:0]              txreq_pkt_cnt,
    output logic [31:0]              tx_pkt_cnt
);

    typedef enum logic {
        ARB,
        TX_BUSY
    } state_e;

    state_e                 state_q, state_d;
    logic                   prio_q, prio_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   out_tvalid_q, out_tvalid_d;
    logic [TDATA_WIDTH-1:0] out_tdata_q, out_tdata_d;
    logic [TKEEP_WIDTH-1:0] out_tkeep_q, out_tkeep_d;
    logic                   out_tlast_q, out_tlast_d;
    logic [USER_W-1:0]      out_tuser_q, out_tuser_d;
    logic                   out_src_q, out_src_d;
    logic [31:0]            txreq_pkt_cnt_q, txreq_pkt_cnt_d;
    logic [31:0]            tx_pkt_cnt_q, tx_pkt_cnt_d;

    logic       adv;
    logic       busy;
    logic       win_tx;
    logic       win_rq;
    logic       tx_rdy;
    logic       rq_rdy;
    logic       tx_acc;
    logic       rq_acc;
    logic       first;
    logic       fire;
    logic [3:0] w_rq;
    logic [3:0] w_tx;
    logic [3:0] w_g;
    logic [4:0] n_g;

    always_comb begin
        adv    = !out_tvalid_q || bus.out_tready;
        busy   = (state_q == TX_BUSY);
        w_rq   = (cfg_txreq_weight == 4'd0) ? 4'd1 : cfg_txreq_weight;
        w_tx   = (cfg_tx_weight == 4'd0) ? 4'd1 : cfg_tx_weight;
        win_tx = bus.tx_tvalid && (prio_q || !bus.txreq_tvalid);
        win_rq = bus.txreq_tvalid && !win_tx;
        // Readies are gated by reset so nothing is consumed while held.
        tx_rdy = hip_rst_n && adv && (busy || win_tx);
        rq_rdy = hip_rst_n && adv && !busy && win_rq;
        tx_acc = tx_rdy && bus.tx_tvalid;
        rq_acc = rq_rdy && bus.txreq_tvalid;
        first  = !busy && (tx_acc || rq_acc);
        w_g    = tx_acc ? w_tx : w_rq;
        n_g    = (tx_acc == prio_q) ? ({1'b0, cnt_q} + 5'd1) : 5'd1;
        fire   = out_tvalid_q && bus.out_tready && out_tlast_q;
    end

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        cnt_d   = cnt_q;
        if (tx_acc) begin
            state_d = bus.tx_tlast ? ARB : TX_BUSY;
        end
        if (first) begin
            if (n_g >= {1'b0, w_g}) begin
                prio_d = ~tx_acc;
                cnt_d  = 4'd0;
            end else begin
                prio_d = tx_acc;
                cnt_d  = n_g[3:0];
            end
        end
    end

    always_comb begin
        out_tvalid_d = out_tvalid_q;
        out_tdata_d  = out_tdata_q;
        out_tkeep_d  = out_tkeep_q;
        out_tlast_d  = out_tlast_q;
        out_tuser_d  = out_tuser_q;
        out_src_d    = out_src_q;
        if (adv) begin
            out_tvalid_d = tx_acc || rq_acc;
            unique case (1'b1)
                rq_acc: begin
                    out_tdata_d = '0;
                    out_tkeep_d = '0;
                    out_tlast_d = 1'b1;
                    out_tuser_d = bus.txreq_tuser;
                    out_src_d   = 1'b0;
                end
                tx_acc: begin
                    out_tdata_d = bus.tx_tdata;
                    out_tkeep_d = bus.tx_tkeep;
                    out_tlast_d = bus.tx_tlast;
                    out_tuser_d = bus.tx_tuser;
                    out_src_d   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        txreq_pkt_cnt_d = txreq_pkt_cnt_q;
        tx_pkt_cnt_d    = tx_pkt_cnt_q;
        if (fire) begin
            if (out_src_q) tx_pkt_cnt_d = tx_pkt_cnt_q + 32'd1;
            else           txreq_pkt_cnt_d = txreq_pkt_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge hip_clk or negedge hip_rst_n) begin
        if (!hip_rst_n) begin
            state_q         <= ARB;
            prio_q          <= 1'b1;
            cnt_q           <= 4'd0;
            out_tvalid_q    <= 1'b0;
            out_tdata_q     <= '0;
            out_tkeep_q     <= '0;
            out_tlast_q     <= 1'b0;
            out_tuser_q     <= '0;
            out_src_q       <= 1'b0;
            txreq_pkt_cnt_q <= 32'd0;
            tx_pkt_cnt_q    <= 32'd0;
        end else begin
            state_q         <= state_d;
            prio_q          <= prio_d;
            cnt_q           <= cnt_d;
            out_tvalid_q    <= out_tvalid_d;
            out_tdata_q     <= out_tdata_d;
            out_tkeep_q     <= out_tkeep_d;
            out_tlast_q     <= out_tlast_d;
            out_tuser_q     <= out_tuser_d;
            out_src_q       <= out_src_d;
            txreq_pkt_cnt_q <= txreq_pkt_cnt_d;
            tx_pkt_cnt_q    <= tx_pkt_cnt_d;
        end
    end

    assign bus.txreq_tready = rq_rdy;
    assign bus.tx_tready    = tx_rdy;
    assign bus.out_tvalid   = out_tvalid_q;
    assign bus.out_tdata    = out_tdata_q;
    assign bus.out_tkeep    = out_tkeep_q;
    assign bus.out_tlast    = out_tlast_q;
    assign bus.out_tuser    = out_tuser_q;
    assign bus.out_src      = out_src_q;
    assign txreq_pkt_cnt    = txreq_pkt_cnt_q;
    assign tx_pkt_cnt       = tx_pkt_cnt_q;

endmodule

// File: tb/tb_ofs_fim_pcie_ss_tx_arb.sv
// Randomized bench for the TX arbiter: packet-level WRR reference model and
// an expected-beat queue drive per-cycle ready, output and counter checks.
module tb_ofs_fim_pcie_ss_tx_arb;

    localparam int DW = 512;
    localparam int KW = DW / 8;
    localparam int UW = 259;

    typedef struct {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
        logic [UW-1:0] u;
        logic          s;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  w_rq = 4'd1;
    logic [3:0]  w_tx = 4'd1;
    logic [31:0] rq_cnt;
    logic [31:0] tx_cnt;

    ofs_fim_pcie_ss_tx_arb_if #(
        .TDATA_WIDTH(DW), .TKEEP_WIDTH(KW), .USER_W(UW)
    ) bus ();

    ofs_fim_pcie_ss_tx_arb #(
        .TDATA_WIDTH(DW), .TKEEP_WIDTH(KW), .USER_W(UW)
    ) dut (
        .hip_clk          (clk),
        .hip_rst_n        (rst_n),
        .cfg_txreq_weight (w_rq),
        .cfg_tx_weight    (w_tx),
        .bus              (bus.slave),
        .txreq_pkt_cnt    (rq_cnt),
        .tx_pkt_cnt       (tx_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Reference: whose turn it is and how many packets that side used.
    bit          m_turn;
    int          m_taken;
    bit          m_lock;
    beat_t       expq[$];
    logic [31:0] m_rq_n;
    logic [31:0] m_tx_n;

    // Stimulus knobs and source state.
    int p_rq, p_tx, len_fix, len_max, rdy_mode;
    int rq_budget, tx_budget, tx_left, tx_beats;
    bit wrand, acc_rq, acc_tx;

    task automatic chk(input string tag, input logic [511:0] got,
                       input logic [511:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic bit pct(input int p);
        return $urandom_range(0, 99) < p;
    endfunction

    function automatic int wv(input logic [3:0] w);
        return (w == 4'd0) ? 1 : int'(w);
    endfunction

    task automatic model_reset();
        m_turn  = 1'b1;
        m_taken = 0;
        m_lock  = 1'b0;
        expq.delete();
        m_rq_n  = 32'd0;
        m_tx_n  = 32'd0;
    endtask

    task automatic tx_beat(input bit lst);
        logic [511:0] r;
        r = rnd512();
        bus.tx_tvalid = 1'b1;
        bus.tx_tdata  = rnd512();
        bus.tx_tkeep  = r[KW-1:0];
        bus.tx_tlast  = lst;
        r = rnd512();
        bus.tx_tuser  = r[UW-1:0];
    endtask

    task automatic drive();
        logic [511:0] r;
        int len;
        if (acc_rq) bus.txreq_tvalid = 1'b0;
        if (acc_tx) bus.tx_tvalid = 1'b0;
        acc_rq = 1'b0;
        acc_tx = 1'b0;
        if (!bus.txreq_tvalid && rq_budget != 0 && pct(p_rq)) begin
            r = rnd512();
            bus.txreq_tvalid = 1'b1;
            bus.txreq_tuser  = r[UW-1:0];
            if (rq_budget > 0) rq_budget--;
        end
        if (!bus.tx_tvalid) begin
            if (tx_left > 0) begin
                if (pct(p_tx)) begin
                    tx_beat(tx_left == 1);
                    tx_left--;
                end
            end else if (tx_budget != 0 && pct(p_tx)) begin
                len = (len_fix > 0) ? len_fix : $urandom_range(1, len_max);
                tx_beat(len == 1);
                tx_left = len - 1;
                if (tx_budget > 0) tx_budget--;
            end
        end
        case (rdy_mode)
            0: bus.out_tready = pct(70);
            2: bus.out_tready = ~bus.out_tready;
            default: bus.out_tready = 1'b1;
        endcase
        if (wrand && $urandom_range(0, 19) == 0) begin
            w_rq = 4'($urandom_range(0, 15));
            w_tx = 4'($urandom_range(0, 15));
        end
    endtask

    task automatic cyc();
        bit    adv, g_rq, g_tx, g;
        int    n;
        beat_t e, b;
        @(negedge clk);
        chk("out_tvalid", bus.out_tvalid, expq.size() > 0);
        chk("txreq_cnt", rq_cnt, m_rq_n);
        chk("tx_cnt", tx_cnt, m_tx_n);
        if (expq.size() > 0) begin
            e = expq[0];
            chk("out_tdata", bus.out_tdata, e.d);
            chk("out_tkeep", bus.out_tkeep, e.k);
            chk("out_tlast", bus.out_tlast, e.l);
            chk("out_tuser", bus.out_tuser, e.u);
            chk("out_src", bus.out_src, e.s);
        end
        adv = (expq.size() == 0) || bus.out_tready;
        if (expq.size() > 0 && bus.out_tready) begin
            void'(expq.pop_front());
            if (e.l) begin
                if (e.s) m_tx_n = m_tx_n + 32'd1;
                else     m_rq_n = m_rq_n + 32'd1;
            end
        end
        g_rq = 1'b0;
        g_tx = 1'b0;
        if (m_lock) begin
            g_tx = adv && bus.tx_tvalid;
        end else if (adv) begin
            if (bus.tx_tvalid && (m_turn || !bus.txreq_tvalid)) g_tx = 1'b1;
            else if (bus.txreq_tvalid) g_rq = 1'b1;
        end
        chk("txreq_tready", bus.txreq_tready, g_rq);
        chk("tx_tready", bus.tx_tready, m_lock ? adv : g_tx);
        if (!m_lock && (g_rq || g_tx)) begin
            g = g_tx;
            n = (g == m_turn) ? m_taken + 1 : 1;
            if (n >= (g ? wv(w_tx) : wv(w_rq))) begin
                m_turn  = !g;
                m_taken = 0;
            end else begin
                m_turn  = g;
                m_taken = n;
            end
        end
        if (g_tx) begin
            m_lock = !bus.tx_tlast;
            b = '{bus.tx_tdata, bus.tx_tkeep, bus.tx_tlast, bus.tx_tuser, 1'b1};
            expq.push_back(b);
            tx_beats++;
        end
        if (g_rq) begin
            b = '{'0, '0, 1'b1, bus.txreq_tuser, 1'b0};
            expq.push_back(b);
        end
        acc_rq = g_rq;
        acc_tx = g_tx;
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        rdy_mode = 1;
        p_rq = 100;
        p_tx = 100;
        while ((expq.size() > 0 || bus.txreq_tvalid || bus.tx_tvalid ||
                tx_left > 0 || rq_budget > 0 || tx_budget > 0) && guard < 400) begin
            cyc();
            guard++;
        end
        if (guard >= 400) chk("drain_timeout", 1, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.txreq_tvalid = 1'b0;
        bus.tx_tvalid = 1'b0;
        tx_left = 0;
        acc_rq = 1'b0;
        acc_tx = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        drive();
    endtask

    initial begin
        int guard;
        bus.txreq_tvalid = 1'b1;
        bus.txreq_tuser  = '0;
        bus.tx_tvalid    = 1'b1;
        bus.tx_tdata     = '0;
        bus.tx_tkeep     = '0;
        bus.tx_tlast     = 1'b0;
        bus.tx_tuser     = '0;
        bus.out_tready   = 1'b1;
        p_rq = 100; p_tx = 100; len_fix = 4; len_max = 4; rdy_mode = 1;
        rq_budget = -1; tx_budget = -1; tx_left = 0; tx_beats = 0;
        wrand = 1'b0; acc_rq = 1'b0; acc_tx = 1'b0;
        model_reset();

        #12;
        chk("rst_out_tvalid", bus.out_tvalid, 0);
        chk("rst_txreq_tready", bus.txreq_tready, 0);
        chk("rst_tx_tready", bus.tx_tready, 0);
        chk("rst_txreq_cnt", rq_cnt, 0);
        chk("rst_tx_cnt", tx_cnt, 0);
        do_reset();

        // Weights 1/1, saturated, 4-beat tx packets.
        repeat (60) cyc();
        rq_budget = 0; tx_budget = 0;
        drain();

        // Weights 3/2, single-beat, saturated: 50 packets -> 20 tx / 30 txreq.
        w_rq = 4'd3; w_tx = 4'd2; len_fix = 1;
        rq_budget = -1; tx_budget = -1;
        do_reset();
        guard = 0;
        while (m_rq_n + m_tx_n < 50 && guard < 200) begin
            cyc();
            guard++;
        end
        chk("wrr50_tx", tx_cnt, 20);
        chk("wrr50_txreq", rq_cnt, 30);
        rq_budget = 0; tx_budget = 0;
        drain();

        // Only txreq, 10 beats.
        w_rq = 4'd1; w_tx = 4'd1;
        rq_budget = 10; tx_budget = 0;
        do_reset();
        drain();
        chk("txreq_only_cnt", rq_cnt, 10);

        // Toggling out_tready over 3-beat tx packets with txreq pending.
        len_fix = 3; rdy_mode = 2;
        rq_budget = 3; tx_budget = 3;
        repeat (40) cyc();
        drain();

        // Random traffic, random weights (including 0) and back-pressure.
        len_fix = 0; len_max = 5; rdy_mode = 0; wrand = 1'b1;
        rq_budget = -1; tx_budget = -1;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) begin
                p_rq = $urandom_range(10, 100);
                p_tx = $urandom_range(10, 100);
            end
            cyc();
        end
        wrand = 1'b0;
        rq_budget = 0; tx_budget = 0;
        drain();

        // Reset after beat 2 of a 4-beat tx packet.
        w_rq = 4'd1; w_tx = 4'd1; len_fix = 4;
        rq_budget = 0; tx_budget = 1; tx_beats = 0;
        guard = 0;
        while (tx_beats < 2 && guard < 20) begin
            cyc();
            guard++;
        end
        rst_n = 1'b0;
        bus.txreq_tvalid = 1'b1;
        bus.tx_tvalid = 1'b1;
        #1;
        chk("midrst_out_tvalid", bus.out_tvalid, 0);
        chk("midrst_txreq_cnt", rq_cnt, 0);
        chk("midrst_tx_cnt", tx_cnt, 0);
        chk("midrst_tx_tready", bus.tx_tready, 0);
        chk("midrst_txreq_tready", bus.txreq_tready, 0);
        rq_budget = 1; tx_budget = 1;
        do_reset();
        drain();
        chk("postrst_tx_cnt", tx_cnt, 1);
        chk("postrst_txreq_cnt", rq_cnt, 1);

        // Counter wrap.
        force dut.tx_pkt_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.tx_pkt_cnt_q;
        m_tx_n = 32'hFFFF_FFFF;
        len_fix = 2; rq_budget = 0; tx_budget = 1;
        drain();
        chk("tx_cnt_wrap", tx_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
